// File: rtl/mips_loader_pkg.sv
// Shared loader types and constants: FSM state encoding, word geometry, default load address.
package mips_loader_pkg;

    localparam int          BYTES_PER_WORD    = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } ld_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream ingress plus instruction-memory write port of the program loader.
// master = byte source / memory observer side, slave = the loader.
interface prog_loader_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;

    modport master (
        output in_valid, in_byte, in_last,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_byte, in_last,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/word_packer.sv
// Packs big-endian bytes into a 32-bit word, zero-padding the tail of a word cut short by last.
// Latency: word_o is valid the cycle after the completing byte; full_o is combinational with it.
// Backpressure: none of its own; the caller only strobes byte_vld_i when a byte is accepted.
module word_packer
    import mips_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    input  logic        byte_last_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        full_o = 1'b0;
        if (byte_vld_i) begin
            // The first byte of a word clears the rest, which gives zero padding for free.
            case (idx_q)
                2'd0:    word_d = {byte_dat_i, 24'h0};
                2'd1:    word_d[23:16] = byte_dat_i;
                2'd2:    word_d[15:8]  = byte_dat_i;
                default: word_d[7:0]   = byte_dat_i;
            endcase
            full_o = byte_last_i || (idx_q == 2'(BYTES_PER_WORD - 1));
            idx_d  = full_o ? 2'd0 : idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 2'd0;
            word_q <= 32'h0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a big-endian byte image into instruction memory, then releases the CPU (csum gated by PROG_LOADER_CSUM_EN).
// Latency: im_we one cycle after the byte completing a word; peak one word per 5 cycles.
// Backpressure: in_ready drops during the write cycle and stays low once the image is done.
module prog_loader
    import mips_loader_pkg::*;
#(
    parameter int          IM_DEPTH  = 256,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    prog_loader_if.slave bus,
    output logic        cpu_run,
    output logic [31:0] word_count,
    output logic        overflow,
    output logic [31:0] csum
);

    localparam logic [31:0] DEPTH_W = 32'(IM_DEPTH);

    ld_state_e   state_q;
    logic        in_ready_q;
    logic        im_we_q;
    logic [31:0] im_addr_q;
    logic        cpu_run_q;
    logic [31:0] cnt_q;
    logic        ovf_q;
    logic        last_q;

    logic        accept;
    logic        pk_full;
    logic [31:0] pk_word;

    assign accept = bus.in_valid && in_ready_q;

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_vld_i (accept),
        .byte_dat_i (bus.in_byte),
        .byte_last_i(bus.in_last),
        .word_o     (pk_word),
        .full_o     (pk_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= 32'h0;
            cpu_run_q  <= 1'b0;
            cnt_q      <= 32'h0;
            ovf_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (pk_full) begin
                        state_q    <= WRITE;
                        in_ready_q <= 1'b0;
                        last_q     <= bus.in_last;
                        // A full memory still consumes the word so the image drains to its last byte.
                        if (cnt_q >= DEPTH_W) begin
                            ovf_q <= 1'b1;
                        end else begin
                            im_we_q   <= 1'b1;
                            im_addr_q <= BASE_ADDR + {cnt_q[29:0], 2'b00};
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                WRITE: begin
                    im_we_q <= 1'b0;
                    if (im_we_q) cnt_q <= cnt_q + 32'd1;
                    if (last_q) begin
                        state_q   <= DONE;
                        cpu_run_q <= 1'b1;
                    end else begin
                        state_q    <= LOAD;
                        in_ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    in_ready_q <= 1'b0;
                end
                default: begin
                    state_q    <= LOAD;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PROG_LOADER_CSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 32'h0;
        end else if (state_q == WRITE && im_we_q) begin
            csum_q <= csum_q ^ pk_word;
        end
    end

    assign csum = csum_q;
`else
    assign csum = 32'h0;
`endif

    assign bus.in_ready = in_ready_q;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = pk_word;
    assign cpu_run      = cpu_run_q;
    assign word_count   = cnt_q;
    assign overflow     = ovf_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter IM_DEPTH, default 256, instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word written; PC reset value.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream byte valid.
REQ-006 SHALL have port in_byte  input  8  program byte, big-endian order (MSB of each word first).
REQ-007 SHALL have port in_last  input  1  qualifies the final byte of the image.
REQ-008 SHALL have port in_ready  output  1  loader can accept a byte.
REQ-009 SHALL have port im_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port im_addr  output  32  byte address of im_wdata, word-aligned.
REQ-011 SHALL have port im_wdata  output  32  assembled instruction word.
REQ-012 SHALL have port cpu_run  output  1  releases the CPU; low holds the PC at BASE_ADDR.
REQ-013 SHALL have port word_count  output  32  words committed so far.
REQ-014 SHALL have port overflow  output  1  sticky; image exceeded IM_DEPTH.
REQ-015 SHALL have port csum  output  32  XOR of all committed words.

Function
REQ-016 SHALL implement FSM states LOAD, WRITE, DONE; reset state LOAD.
REQ-017 SHALL drive in_ready=1 only in LOAD; a byte is accepted on an edge where in_valid && in_ready.
REQ-018 SHALL shift accepted bytes into a 32-bit assembly register MSB-first; byte index counts 0..3.
REQ-019 SHALL go LOAD->WRITE on acceptance of the 4th byte or of any byte with in_last=1.
REQ-020 SHALL zero-pad the unfilled low bytes of a partial word terminated by in_last (e.g. bytes AA,BB+last -> 32'hAABB_0000).
REQ-021 SHALL assert im_we for exactly one cycle in WRITE, with im_addr = BASE_ADDR + 4*word_count and im_wdata the assembled word; latency is one cycle after the accepting edge.
REQ-022 SHALL, at the end of WRITE, increment word_count and XOR im_wdata into csum, then go to DONE if the word ended with in_last, else to LOAD with byte index 0.
REQ-023 SHALL, when word_count == IM_DEPTH on entry to WRITE, suppress im_we, set overflow, and leave word_count and csum unchanged; bytes are still accepted and discarded until in_last.
REQ-024 SHALL, in DONE, hold cpu_run=1, in_ready=0, im_we=0 until reset; in_valid is ignored.
REQ-025 SHALL never let word_count wrap; maximum value IM_DEPTH.
REQ-026 SHALL give peak throughput of one word per 5 cycles (4 accepts + 1 write).

Reset
REQ-027 SHALL, on rst_n low, immediately clear state to LOAD and clear in_ready, im_we, im_addr, im_wdata, cpu_run, word_count, overflow, csum, the byte index and the assembly register; in_ready rises on the first edge after release.
REQ-028 SHALL, on reset mid-word or mid-WRITE, discard the partial word with no im_we pulse.

Configuration
REQ-029 SHALL, with macro PROG_LOADER_CSUM_EN defined, compute csum per REQ-022; without it, csum SHALL be constant 0 and no checksum register synthesised.

Structure
REQ-030 SHALL place the state enum, BYTES_PER_WORD=4 and the default BASE_ADDR in shared package mips_loader_pkg.
REQ-031 SHALL isolate the byte packing and zero padding in sub-module word_packer (bytes in, word plus full flag out).

Verification
REQ-032 SHALL cover: reset, 8 bytes 00,00,00,20 / 8C,01,00,04 with last on byte 8 -> writes {0x0,0x00000020},{0x4,0x8C010004}, word_count=2, csum=0x8C010024, cpu_run=1.
REQ-033 SHALL cover: 6 bytes 11,22,33,44,55,66+last -> second write 0x55660000 at 0x4.
REQ-034 SHALL cover: IM_DEPTH=2, 12 bytes -> two writes only, overflow=1, word_count=2, cpu_run=1 after last.
REQ-035 SHALL cover: in_valid toggled every other cycle -> same memory contents as back-to-back; no byte accepted while in_ready=0.
REQ-036 SHALL cover: rst_n pulsed low after 2 bytes of word 1 -> no im_we, all outputs 0, subsequent 4-byte image written at BASE_ADDR.
REQ-037 SHALL cover: build without PROG_LOADER_CSUM_EN -> REQ-032 stimulus gives csum=0, other results identical.
